mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters. It grants exactly one requester at a time and drives the mux select. It also registers the selected lane onto a shared output and forcibly revokes a grant held longer than a bounded number of cycles. It sits in front of the 4:1 mux datapath; downstream logic sees one arbitrated stream.

Parameters:
DATA_W, 1, width of each requester lane and of out_data
MAX_HOLD, 8, maximum consecutive cycles one grant may be held (legal range 2..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  4  request per lane; bit i = requester i
done  input  4  one-cycle release pulse per lane; only the holder's bit is honoured
in_data  input  4*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
gnt  output  4  one-hot grant, registered, all-zero when idle
sel  output  2  mux select = index of current holder; holds last value when idle
valid  output  1  high while any gnt bit is set
out_data  output  DATA_W  registered selected lane; zero when not valid
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values: gnt=0, sel=0, valid=0, out_data=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0.
- Reset asserted mid-grant clears all outputs immediately, with no clock edge needed.
- State machine has two states, IDLE and GRANT.
- IDLE: if req != 0, choose the first set bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: gnt=onehot(winner), sel=winner, valid=1, hold_cnt=0, ptr=winner+1 mod 4, state=GRANT.
  - If req == 0, remain in IDLE.
- GRANT with holder h:
  - Release when any of these holds: req[h]=0, done[h]=1, or hold_cnt==MAX_HOLD-1.
  - On release, next edge: gnt=0, valid=0, state=IDLE.
  - Otherwise hold_cnt increments.
- After every release, gnt stays zero for exactly one cycle before the next grant. There are no back-to-back grants.
- Timeout: timeout pulses in the cycle after release only when the release cause is hold_cnt==MAX_HOLD-1 while req[h]=1 and done[h]=0.
  - If done[h] and the limit coincide, the release is treated as done and no timeout pulse is issued.
  - req[h]=0 coinciding with the limit also produces no pulse.
- Grant latency: 1 cycle from req seen in IDLE to gnt high.
- sel changes only on a grant edge.
- done and req changes on non-holder lanes are ignored while in GRANT. done in IDLE is ignored.
- Fairness: ptr advances past the winner, so a released holder that re-requests immediately has lowest priority. Each continuously requesting lane is granted within 3 intervening grants.
- out_data is registered: out_data(t+1) = in_data lane sel(t) if valid(t), else 0. The output trails gnt by one cycle, and the final holder's data appears on the cycle after gnt drops.
- hold_cnt is 8 bits wide and never wraps, because release occurs at MAX_HOLD-1.

Test Plan:
- Reset with req=4'b1111 → gnt=0, sel=0, valid=0. One cycle after rst drops → gnt=0001, sel=0.
- req=0100 only, held; done[2] pulsed at the 3rd grant cycle → gnt=0100 for 3 cycles, then 0000 for 1 cycle, then 0100 again, timeout=0 throughout.
- req=1111 held, MAX_HOLD=8, no done → grant sequence 0001,0010,0100,1000,0001. Each grant lasts 8 cycles with a 1-cycle gap, and each gap carries timeout=1.
- Holder 1 active, done[1] and hold_cnt==7 in the same cycle → release, timeout stays 0. done[3] pulsed while lane 1 holds → ignored.
- DATA_W=4, in_data=16'hA5C3, grant to lane 2 → out_data=4'h5 on the cycle after gnt=0100. out_data=0 two cycles after the release edge.
- Assert rst asynchronously mid-grant of lane 3 → gnt/valid/out_data zero before the next clk edge. After release of rst, ptr=0, so req=1001 grants lane 0 first.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux among four requesters.
// Grants one lane at a time, registers the selected lane, and revokes over-long grants.
module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            done,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [1:0]        ptr, ptr_nxt;
  logic [7:0]        hold_cnt, hold_nxt;
  logic [3:0]        gnt_nxt;
  logic [1:0]        sel_nxt;
  logic              valid_nxt, to_nxt;
  logic [1:0]        win;
  logic              win_vld;
  logic              at_lim;
  logic [DATA_W-1:0] lane [4];

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = in_data[i*DATA_W +: DATA_W];
  end

  // Scan from ptr downward in reverse so the last hit is the first lane at or after ptr.
  always_comb begin
    win     = ptr;
    win_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        win     = ptr + 2'(k);
        win_vld = 1'b1;
      end
    end
  end

  assign at_lim = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    valid_nxt = valid;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << win;
          sel_nxt   = win;
          valid_nxt = 1'b1;
          hold_nxt  = 8'd0;
          ptr_nxt   = win + 2'd1;
        end
      end
      GRANT: begin
        if (!req[sel] || done[sel] || at_lim) begin
          state_nxt = IDLE;
          gnt_nxt   = 4'b0000;
          valid_nxt = 1'b0;
          hold_nxt  = 8'd0;
          // Only a pure limit expiry counts as a revocation.
          to_nxt    = at_lim && req[sel] && !done[sel];
        end else begin
          hold_nxt  = hold_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      valid    <= 1'b0;
      timeout  <= 1'b0;
      out_data <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      valid    <= valid_nxt;
      timeout  <= to_nxt;
      out_data <= valid ? lane[sel] : '0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: per-cycle expectations are queued, then popped as the DUT runs.
module tb_mux4_rr_arbiter;

  localparam int DATA_W   = 4;
  localparam int MAX_HOLD = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          req, done;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                valid;
  logic [DATA_W-1:0]   out_data;
  logic                timeout;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    logic [3:0]        gnt;
    logic              to;
    logic              chk_od;
    logic [DATA_W-1:0] od;
  } exp_t;

  exp_t q[$];
  exp_t e;

  mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .in_data(in_data),
    .gnt(gnt), .sel(sel), .valid(valid), .out_data(out_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input logic to, input logic c, input logic [DATA_W-1:0] od);
    exp_t x;
    x.gnt = g; x.to = to; x.chk_od = c; x.od = od;
    q.push_back(x);
  endtask

  task automatic local_reset();
    rst = 1'b1; req = 4'b0000; done = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 4'b0000; in_data = '0;
    step(); step();
    ntests++;
    if (gnt !== 4'b0000 || sel !== 2'd0 || valid !== 1'b0 || out_data !== '0 || timeout !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: gnt=%b sel=%0d valid=%b od=%h to=%b, want all zero", gnt, sel, valid, out_data, timeout);
    end
    rst = 1'b0;
    step();
    ntests++;
    if (gnt !== 4'b0001 || sel !== 2'd0 || valid !== 1'b1) begin
      nfail++;
      $display("FAIL reset_first_grant: gnt=%b sel=%0d valid=%b, want 0001 0 1", gnt, sel, valid);
    end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_done_release();
    local_reset();
    req = 4'b0100;
    push(4'b0100, 0, 0, '0); push(4'b0100, 0, 0, '0); push(4'b0100, 0, 0, '0);
    push(4'b0000, 0, 0, '0); push(4'b0100, 0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step();
      e = q.pop_front();
      ntests++;
      if (gnt !== e.gnt || timeout !== e.to) begin
        nfail++;
        $display("FAIL done_release[%0d]: gnt=%b to=%b, want %b %b", i, gnt, timeout, e.gnt, e.to);
      end
      done = (i == 2) ? 4'b0100 : 4'b0000;
    end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_timeout_rr();
    local_reset();
    req = 4'b1111;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < MAX_HOLD; c++) push(4'b0001 << l, 0, 0, '0);
      push(4'b0000, 1, 0, '0);
    end
    push(4'b0001, 0, 0, '0);
    for (int i = 0; i < 4*(MAX_HOLD+1)+1; i++) begin
      step();
      e = q.pop_front();
      ntests++;
      if (gnt !== e.gnt || timeout !== e.to) begin
        nfail++;
        $display("FAIL timeout_rr[%0d]: gnt=%b to=%b, want %b %b", i, gnt, timeout, e.gnt, e.to);
      end
    end
    req = 4'b0000;
    step(); step();
  endtask

  task automatic test_done_at_limit();
    local_reset();
    req = 4'b0010;
    for (int c = 0; c < MAX_HOLD; c++) push(4'b0010, 0, 0, '0);
    push(4'b0000, 0, 0, '0);
    push(4'b0000, 0, 0, '0);
    for (int i = 0; i < MAX_HOLD+2; i++) begin
      step();
      e = q.pop_front();
      ntests++;
      if (gnt !== e.gnt || timeout !== e.to) begin
        nfail++;
        $display("FAIL done_at_limit[%0d]: gnt=%b to=%b, want %b %b", i, gnt, timeout, e.gnt, e.to);
      end
      // Non-holder done at cycle 2, holder done exactly at hold_cnt == MAX_HOLD-1.
      done = (i == 2) ? 4'b1000 : (i == MAX_HOLD-1) ? 4'b0010 : 4'b0000;
      if (i == MAX_HOLD) req = 4'b0000;
    end
    done = 4'b0000;
  endtask

  task automatic test_data_path();
    local_reset();
    in_data = 16'hA5C3;
    req = 4'b0100;
    push(4'b0100, 0, 1, 4'h0);
    push(4'b0100, 0, 1, 4'h5);
    push(4'b0000, 0, 1, 4'h5);
    push(4'b0000, 0, 1, 4'h0);
    push(4'b0000, 0, 1, 4'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      e = q.pop_front();
      ntests++;
      if (gnt !== e.gnt || (e.chk_od && out_data !== e.od)) begin
        nfail++;
        $display("FAIL data_path[%0d]: gnt=%b od=%h, want %b %h", i, gnt, out_data, e.gnt, e.od);
      end
      if (i == 1) req = 4'b0000;
    end
  endtask

  task automatic test_async_reset();
    local_reset();
    in_data = 16'hA5C3;
    req = 4'b1000;
    push(4'b1000, 0, 1, 4'h0);
    push(4'b1000, 0, 1, 4'hA);
    for (int i = 0; i < 2; i++) begin
      step();
      e = q.pop_front();
      ntests++;
      if (gnt !== e.gnt || out_data !== e.od) begin
        nfail++;
        $display("FAIL async_pre[%0d]: gnt=%b od=%h, want %b %h", i, gnt, out_data, e.gnt, e.od);
      end
    end
    #2 rst = 1'b1;
    #1;
    ntests++;
    if (gnt !== 4'b0000 || valid !== 1'b0 || out_data !== '0 || sel !== 2'd0 || timeout !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: gnt=%b valid=%b od=%h sel=%0d, want zeros", gnt, valid, out_data, sel);
    end
    step();
    rst = 1'b0;
    req = 4'b1001;
    step();
    ntests++;
    if (gnt !== 4'b0001 || sel !== 2'd0) begin
      nfail++;
      $display("FAIL async_ptr: gnt=%b sel=%0d, want 0001 0", gnt, sel);
    end
    req = 4'b0000;
    step(); step();
  endtask

  initial begin
    rst = 1'b1; req = 4'b0000; done = 4'b0000; in_data = '0;
    test_reset();
    test_done_release();
    test_timeout_rr();
    test_done_at_limit();
    test_data_path();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
